score_level_counter: RTL
========================

// Module: score_level_counter
// PURPOSE
//  Parametrised BCD score/level tracker for the game core. Replaces the
//  free-running score counter with a clocked design that has weighted point
//  adds, a freeze on game over, level progression and saturation. Sits
//  between the game FSM (add/gameover/clear strobes) and the 7-seg/VGA score
//  display, which reads score and level directly.
// PARAMETERS
//  DIGITS      4    BCD digits of score; score width = 4*DIGITS
//  LEVEL_STEP  20   points per level; must be >= 10 (at most one level-up per add)
//  MAX_LEVEL   9    level saturates here
//  LEVEL_W     4    width of level output; must hold MAX_LEVEL
// PORTS
//  clk         in   1          system clock, all state on rising edge
//  rst         in   1          synchronous, active-high reset
//  clear       in   1          start new game: zero score/level, keep high score
//  gameover    in   1          freeze scoring (level or pulse)
//  add_en      in   1          add add_pts this cycle
//  add_pts     in   4          points to add, binary 0..9 (values >9 clamp to 9)
//  score       out  4*DIGITS   BCD score
//  level       out  LEVEL_W    current level, 0..MAX_LEVEL
//  levelup     out  1          1-cycle pulse when level increments
//  saturated   out  1          score stuck at all-9s
//  high_score  out  4*DIGITS   best final score (see CONFIGURATION)
//  new_record  out  1          1-cycle pulse when high_score updates
// BEHAVIOUR
//  - Reset (rst=1 at edge): score=0, level=0, levelup=0, saturated=0,
//    high_score=0, new_record=0, state=RUN, to_next=LEVEL_STEP.
//  - States: RUN (adds accepted), FROZEN (adds ignored).
//    RUN --gameover--> FROZEN; FROZEN --clear--> RUN; RUN --clear--> RUN.
//  - Priority per edge: rst > clear > gameover > add_en.
//  - clear: score=0, level=0, saturated=0, to_next=LEVEL_STEP, state=RUN.
//  - Add (RUN, add_en=1): score <= score + min(add_pts,9), ripple-carry BCD
//    add on the units digit. Latency 1: registered score visible the cycle
//    after add_en. add_pts=0 is legal and changes nothing.
//  - Saturation: if the add would overflow DIGITS digits, score = all 9s and
//    saturated=1. Later adds leave score unchanged until clear/rst.
//  - Level: binary down-counter to_next, decremented by the points added. If
//    the result is <= 0: level++ (only if level < MAX_LEVEL), levelup=1 in the
//    same cycle score updates, to_next += LEVEL_STEP. At MAX_LEVEL no pulses
//    are produced; to_next still reloads. A saturating add that clips still
//    uses the clipped delta.
//  - gameover and add_en together in RUN: the add is dropped and the block
//    enters FROZEN. gameover held high while FROZEN has no further effect.
//  - clear and add_en together: clear wins and the add is dropped.
//  - rst mid-operation discards everything, including high_score.
// CONFIGURATION
//  HIGH_SCORE_EN defined: on the RUN->FROZEN transition, if score >
//    high_score (BCD compare), high_score <= score and new_record pulses for
//    1 cycle. Equal scores do not update. clear does not touch high_score.
//  HIGH_SCORE_EN undefined: no high-score register is built. high_score is
//    tied to 0 and new_record to 0. All other behaviour is identical.
// TESTING (DIGITS=4, LEVEL_STEP=20, HIGH_SCORE_EN defined)
//  1 rst for 1 cycle -> score=0000, level=0, levelup=0, saturated=0, high_score=0000
//  2 add_en with add_pts=7, three times -> score 0007, 0014, 0021; on the third
//    update levelup pulses 1 cycle and level=1
//  3 add_pts=15 at score 0000 -> score=0009 (clamp)
//  4 preload to 9995 via adds, then add 9 -> score=9999, saturated=1;
//    then add 1 -> score stays 9999
//  5 at score 0021, gameover+add_en in the same cycle -> score stays 0021,
//    state FROZEN, later adds ignored; new_record pulses, high_score=0021;
//    then clear -> score=0000, level=0
//  6 second game ends at 0014 -> high_score stays 0021, no new_record;
//    then rst mid-game -> everything 0 on the next edge

Source files
------------

// File: rtl/score_level_counter.sv
// -----------------------------------------------------------------------------
// score_level_counter
//   BCD score and level tracker for the game core. The game FSM drives the
//   add/gameover/clear strobes. The score display reads score and level
//   directly.
//
//   Weighted adds are clamped to 0..9. The score is kept as packed BCD, and
//   it saturates at all nines. A binary down-counter counts the points left
//   until the next level. Scoring freezes on game over and restarts on clear.
//
//   Optional feature: define HIGH_SCORE_EN to build the high-score register.
//   Without it, high_score and new_record are tied to zero.
//
// Ports
//   clk          system clock; all state changes on the rising edge
//   rst          synchronous, active-high reset
//   clear        start a new game (zeroes score/level, keeps high_score)
//   gameover     freeze scoring (level or pulse)
//   add_en       add add_pts this cycle
//   add_pts      points to add, binary; values above 9 clamp to 9
//   score        packed BCD score, DIGITS digits
//   level        current level, 0..MAX_LEVEL
//   levelup      1-cycle pulse when level increments
//   saturated    score is stuck at all nines
//   high_score   best final score (0 when HIGH_SCORE_EN is undefined)
//   new_record   1-cycle pulse when high_score updates
// -----------------------------------------------------------------------------
//  state      | meaning
//  ST_RUN     | adds accepted; gameover freezes
//  ST_FROZEN  | adds ignored; only clear or rst leave
// -----------------------------------------------------------------------------
module score_level_counter #(
  parameter int DIGITS     = 4,
  parameter int LEVEL_STEP = 20,
  parameter int MAX_LEVEL  = 9,
  parameter int LEVEL_W    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  gameover,
  input  logic                  add_en,
  input  logic [3:0]            add_pts,
  output logic [4*DIGITS-1:0]   score,
  output logic [LEVEL_W-1:0]    level,
  output logic                  levelup,
  output logic                  saturated,
  output logic [4*DIGITS-1:0]   high_score,
  output logic                  new_record
);

  localparam logic [0:0] ST_RUN    = 1'b0;
  localparam logic [0:0] ST_FROZEN = 1'b1;

  // The counter holds 1..LEVEL_STEP between adds. It can dip to -8 before
  // the reload, so it needs a sign bit plus headroom.
  localparam int TN_W = $clog2(LEVEL_STEP + 1) + 2;
  localparam logic signed [TN_W-1:0] STEP_S    = TN_W'(LEVEL_STEP);
  localparam logic [LEVEL_W-1:0]     LVL_MAX   = LEVEL_W'(MAX_LEVEL);
  localparam logic [4*DIGITS-1:0]    ALL_NINES = {DIGITS{4'h9}};

  logic [0:0]              state;
  logic signed [TN_W-1:0]  to_next;

  logic [3:0]              pts_clamped;
  logic [4*DIGITS-1:0]     sum_bcd;
  logic                    carry_out;
  logic [4:0]              digit_acc;
  logic [4:0]              digit_cin;
  logic [3:0]              delta;
  logic signed [TN_W-1:0]  tn_sub;
  logic signed [TN_W-1:0]  tn_next;
  logic                    lvl_hit;
  logic                    go_evt;

  assign pts_clamped = (add_pts > 4'd9) ? 4'd9 : add_pts;

  // Ripple-carry BCD add. The binary delta enters as the carry into the
  // units digit, and each higher digit only ever sees a carry of 0 or 1.
  always_comb begin
    sum_bcd   = '0;
    digit_acc = '0;
    digit_cin = {1'b0, pts_clamped};
    for (int i = 0; i < DIGITS; i++) begin
      digit_acc = {1'b0, score[4*i +: 4]} + digit_cin;
      if (digit_acc >= 5'd10) begin
        sum_bcd[4*i +: 4] = 4'(digit_acc - 5'd10);
        digit_cin         = 5'd1;
      end else begin
        sum_bcd[4*i +: 4] = digit_acc[3:0];
        digit_cin         = 5'd0;
      end
    end
    carry_out = (digit_cin != 5'd0);
  end

  // On overflow, the wrapped sum is below 10, so only its units digit is
  // non-zero. The points that actually land are all-nines minus the old
  // score, which equals pts - wrapped_units - 1.
  always_comb begin
    delta   = carry_out ? (pts_clamped - sum_bcd[3:0] - 4'd1) : pts_clamped;
    tn_sub  = to_next - $signed({{(TN_W-4){1'b0}}, delta});
    lvl_hit = (tn_sub <= 0);
    tn_next = lvl_hit ? (tn_sub + STEP_S) : tn_sub;
  end

  assign go_evt = (state == ST_RUN) && !clear && gameover;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_RUN;
      score     <= '0;
      level     <= '0;
      levelup   <= 1'b0;
      saturated <= 1'b0;
      to_next   <= STEP_S;
    end else begin
      levelup <= 1'b0;
      if (clear) begin
        state     <= ST_RUN;
        score     <= '0;
        level     <= '0;
        saturated <= 1'b0;
        to_next   <= STEP_S;
      end else if (state == ST_RUN) begin
        if (gameover) begin
          state <= ST_FROZEN;
        end else if (add_en) begin
          if (carry_out) begin
            score     <= ALL_NINES;
            saturated <= 1'b1;
          end else begin
            score <= sum_bcd;
          end
          to_next <= tn_next;
          if (lvl_hit && (level < LVL_MAX)) begin
            level   <= level + 1'b1;
            levelup <= 1'b1;
          end
        end
      end
    end
  end

`ifdef HIGH_SCORE_EN
  // Packed BCD orders the same way as its decimal value, so a plain
  // unsigned compare is enough here.
  always_ff @(posedge clk) begin
    if (rst) begin
      high_score <= '0;
      new_record <= 1'b0;
    end else begin
      new_record <= 1'b0;
      if (go_evt && (score > high_score)) begin
        high_score <= score;
        new_record <= 1'b1;
      end
    end
  end
`else
  assign high_score = '0;
  assign new_record = 1'b0;
`endif

endmodule
